// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 6-digit multiplexed 7-segment display.
// Holds shadow and active digit buffers. The CPU writes the shadow buffer.
// The shadow buffer is copied to the active buffer only at a frame boundary,
// or while the scanner is idle.
// Each digit slot has a short blanking gap followed by the show phase.
// All outputs are registered. They are computed from the next-state values,
// so each output cycle matches the state/idx held in that same cycle.
module seg_scan_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    output logic [5:0] dig,
    output logic [6:0] out,
    output logic       frame_done
);

    localparam int              CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]   SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [6:0]      SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [4:0]      DIGIT_BLANK = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [5:0][4:0] shadow_q, shadow_d;
    logic [5:0][4:0] active_q, active_d;

    logic [5:0]      dig_d;
    logic [6:0]      out_d;
    logic            frame_done_d;
    logic [6:0]      seg_raw;
    logic            commit_req;

    // Store port protocol: this is a fire-and-forget strobe with no ready signal.
    // A store is accepted in every cycle where wr_en is high.
    // Addresses 0-5 write the shadow digit, address 6 requests a commit, and address 7 is dropped.

    // Hex digit to {g..a}; bit 4 set means the digit is blanked.
    function automatic logic [6:0] seg_decode(input logic [4:0] d);
        logic [6:0] s;
        case (d[3:0])
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        if (d[4]) begin
            s = 7'h00;
        end
        return s;
    endfunction

    // Next-state logic: store port, scan sequencing and buffer commit.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        commit_req = wr_en && (wr_addr == 3'd6);

        for (int i = 0; i < 6; i++) begin
            if (wr_en && (wr_addr == 3'(i))) begin
                shadow_d[i] = wr_data;
            end
        end
        if (commit_req) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // Nothing is on screen, so a pending commit can land right away.
                if (pend_q) begin
                    active_d = shadow_q;
                    pend_d   = commit_req;
                end
                if (enable) begin
                    state_d = ST_BLANK;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end
            end
            ST_BLANK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHOW: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end else if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == 3'd5) begin
                        // Frame boundary. The copy uses the registered shadow,
                        // so a digit store in this same cycle is not captured.
                        idx_d = 3'd0;
                        if (pend_q || commit_req) begin
                            active_d = shadow_q;
                            pend_d   = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from next-state values, so the registered outputs line up with the state.
    always_comb begin
        dig_d        = 6'b111111;
        seg_raw      = 7'h00;
        frame_done_d = 1'b0;
        if (state_d != ST_IDLE) begin
            seg_raw = seg_decode(active_d[idx_d]);
        end
        for (int i = 0; i < 6; i++) begin
            if ((state_d == ST_SHOW) && (idx_d == 3'(i))) begin
                dig_d[i] = 1'b0;
            end
        end
        frame_done_d = (state_d == ST_SHOW) && (idx_d == 3'd5) && (cnt_d == SHOW_LAST);
        out_d        = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    end

    // State, buffer and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            shadow_q   <= {6{DIGIT_BLANK}};
            active_q   <= {6{DIGIT_BLANK}};
            dig        <= 6'b111111;
            out        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            dig        <= dig_d;
            out        <= out_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=10 and BLANK_CYC=2.
// A slot is 2 blank cycles followed by 8 show cycles, and a frame is 60 cycles.
// cyc counts cycles from the first BLANK cycle after enable.
// The expected digit patterns are hand-set in exp_seg.
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV  = 10;
    localparam int BLANK_CYC = 2;

    logic       CLK;
    logic       RESET;
    logic       enable;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [5:0] dig;
    logic [6:0] out;
    logic       frame_done;

    int         errors;
    int         checks;
    int         cyc;
    string      phase;
    logic [6:0] exp_seg [6];

    seg_scan_ctrl #(
        .SCAN_DIV      (SCAN_DIV),
        .BLANK_CYC     (BLANK_CYC),
        .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .enable    (enable),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dig       (dig),
        .out       (out),
        .frame_done(frame_done)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s cyc=%0d: got %0h expected %0h", phase, tag, cyc, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_edge();
        @(posedge CLK);
        #1;
    endtask

    // Check a dark display (idle or reset) and advance one cycle.
    task automatic idle_check();
        @(negedge CLK);
        check("dig", 32'(dig), 32'h3F);
        check("out", 32'(out), 32'h00);
        check("frame_done", 32'(frame_done), 32'h0);
        next_edge();
    endtask

    // Check one scanning cycle against the slot timeline, then advance.
    task automatic step_check();
        int         slot;
        int         ph;
        logic [5:0] d;
        slot = (cyc / SCAN_DIV) % 6;
        ph   = cyc % SCAN_DIV;
        d    = 6'h3F;
        if (ph >= BLANK_CYC) d[slot] = 1'b0;
        @(negedge CLK);
        check("dig", 32'(dig), 32'(d));
        check("out", 32'(out), 32'(exp_seg[slot]));
        check("frame_done", 32'(frame_done), ((cyc % 60) == 59) ? 32'h1 : 32'h0);
        next_edge();
        cyc++;
    endtask

    task automatic run_to(input int end_c);
        while (cyc < end_c) step_check();
    endtask

    task automatic step_store(input logic [2:0] a, input logic [4:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step_check();
        wr_en   = 1'b0;
    endtask

    task automatic idle_store(input logic [2:0] a, input logic [4:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        idle_check();
        wr_en   = 1'b0;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        cyc     = 0;
        RESET   = 1'b1;
        enable  = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 5'd0;
        for (int i = 0; i < 6; i++) exp_seg[i] = 7'h00;

        // 1: reset held with enable high, then the first scan shows blanks
        phase = "reset";
        repeat (2) next_edge();
        repeat (3) idle_check();
        RESET = 1'b0;
        phase = "release";
        idle_check();
        cyc   = 0;
        phase = "blank_scan";
        run_to(12);

        // 2: disable, load digits 1..6, commit while idle, then scan
        enable = 1'b0;
        step_check();
        phase = "idle_load";
        idle_check();
        for (int i = 0; i < 6; i++) idle_store(3'(i), 5'(i + 1));
        idle_store(3'd6, 5'd0);
        repeat (2) idle_check();
        enable = 1'b1;
        idle_check();
        cyc        = 0;
        exp_seg[0] = 7'h06;
        exp_seg[1] = 7'h5B;
        exp_seg[2] = 7'h4F;
        exp_seg[3] = 7'h66;
        exp_seg[4] = 7'h6D;
        exp_seg[5] = 7'h7D;
        phase = "frame1";
        run_to(60);

        // 3: during digit 2, store digit 0 = A and commit; it lands at the next frame
        phase = "midframe_commit";
        run_to(85);
        step_store(3'd0, 5'h0A);
        step_store(3'd6, 5'd0);
        run_to(120);
        exp_seg[0] = 7'h77;

        // 4: blank digit 3 in shadow only, then commit exactly in the last cycle of a frame
        phase = "shadow_only";
        run_to(125);
        step_store(3'd3, 5'h10);
        run_to(359);
        step_store(3'd6, 5'd0);
        exp_seg[3] = 7'h00;
        phase = "boundary_commit";

        // 5: drop enable during the show phase of digit 4, then restart from slot 0
        run_to(405);
        enable = 1'b0;
        step_check();
        phase = "disabled";
        repeat (3) idle_check();
        enable = 1'b1;
        idle_check();
        cyc   = 0;
        phase = "restart";
        run_to(30);
        step_store(3'd6, 5'd0);
        run_to(59);
        // A digit store in the boundary cycle must miss this commit.
        step_store(3'd1, 5'h0F);
        phase = "boundary_store";
        run_to(135);

        // 6: reset during a show phase while a commit is pending
        step_store(3'd6, 5'd0);
        run_to(145);
        RESET = 1'b1;
        step_check();
        RESET = 1'b0;
        phase = "after_reset";
        idle_check();
        cyc = 0;
        for (int i = 0; i < 6; i++) exp_seg[i] = 7'h00;
        run_to(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
